// File: rtl/debounce_sync_if.sv
// Signal bundle between the raw input source and the debounce/synchronizer block.
interface debounce_sync_if;
    logic din_async;
    logic dout;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    // Source side: drives the raw input, observes the conditioned level and pulses.
    modport master (
        output din_async,
        input  dout,
        input  rise_pulse,
        input  fall_pulse,
        input  busy
    );

    // Debouncer side: consumes the raw input, produces the conditioned outputs.
    modport slave (
        input  din_async,
        output dout,
        output rise_pulse,
        output fall_pulse,
        output busy
    );
endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a stability-qualified level FSM. The debounced
// level changes only after STABLE_CYCLES consecutive synchronized samples at the new
// value; each change is marked by a one-cycle rise or fall pulse.
module debounce_sync #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic            clk,
    input logic            rst_n,
    debounce_sync_if.slave bus
);

    typedef enum logic [1:0] {
        StLow     = 2'b00,
        StChkHigh = 2'b01,
        StHigh    = 2'b10,
        StChkLow  = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

    logic             sync0_q;
    logic             sync1_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dout_q;
    logic             rise_q;
    logic             fall_q;
    logic             busy_q;

    // Bring the raw input into the clk domain; only sync1_q is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
        end else begin
            sync0_q <= bus.din_async;
            sync1_q <= sync0_q;
        end
    end

    // Qualification FSM with registered level, pulses and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLow;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                StLow: begin
                    if (sync1_q) begin
                        state_q <= StChkHigh;
                        cnt_q   <= CntOne;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                StChkHigh: begin
                    // Reversion wins over qualification on the same cycle.
                    if (!sync1_q) begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CntLast) begin
                        state_q <= StHigh;
                        cnt_q   <= '0;
                        dout_q  <= 1'b1;
                        rise_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StHigh: begin
                    if (!sync1_q) begin
                        state_q <= StChkLow;
                        cnt_q   <= CntOne;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                StChkLow: begin
                    if (sync1_q) begin
                        state_q <= StHigh;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CntLast) begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                        dout_q  <= 1'b0;
                        fall_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                default: begin
                    state_q <= StLow;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: a run-length reference model pushes the
// expected {dout, rise, fall, busy} per clock into a queue, popped after each edge.
module tb_debounce_sync;

    localparam int unsigned StableCycles = 4;
    localparam int          Latency      = StableCycles + 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    debounce_sync_if bus ();

    debounce_sync #(
        .CNT_W        (16),
        .STABLE_CYCLES(StableCycles)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_q[$];
    logic       m_s0;
    logic       m_s1;
    logic       m_dout;
    int         m_run;
    int         rise_cnt;
    int         fall_cnt;
    logic [3:0] obs;
    logic [3:0] hist[8];
    int         lat;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] dut_outs();
        return {bus.dout, bus.rise_pulse, bus.fall_pulse, bus.busy};
    endfunction

    task automatic model_reset();
        m_s0   = 1'b0;
        m_s1   = 1'b0;
        m_dout = 1'b0;
        m_run  = 0;
        exp_q.delete();
    endtask

    // Level flips once the synchronized input has disagreed with it for
    // StableCycles consecutive edges; any agreeing sample restarts the run.
    task automatic model_step(input logic d);
        logic rise;
        logic fall;
        rise = 1'b0;
        fall = 1'b0;
        if (m_s1 != m_dout) begin
            m_run++;
            if (m_run == int'(StableCycles)) begin
                m_dout = ~m_dout;
                rise   = m_dout;
                fall   = ~m_dout;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
        exp_q.push_back({m_dout, rise, fall, (m_run != 0)});
        m_s1 = m_s0;
        m_s0 = d;
    endtask

    task automatic tick(input logic d, input string tag);
        logic [3:0] e;
        @(negedge clk);
        bus.din_async = d;
        model_step(d);
        @(posedge clk);
        #1;
        obs = dut_outs();
        if (obs[2]) rise_cnt++;
        if (obs[1]) fall_cnt++;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard empty got=%b", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, 32'(obs), 32'(e));
        end
    endtask

    // Hold d until dout reaches it; lat is the edge index (0 = first capture).
    task automatic run_latency(input logic d, input string tag, output int l);
        l = -1;
        for (int i = 0; i < 20; i++) begin
            tick(d, tag);
            if (bus.dout == d) begin
                l = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rise_cnt      = 0;
        fall_cnt      = 0;
        rst_n         = 1'b1;
        bus.din_async = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_val("reset_init", 32'(dut_outs()), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) tick(1'b0, "idle_low");

        // Glitch: three high samples never qualify.
        rise_cnt = 0;
        repeat (3) tick(1'b1, "glitch_hi");
        repeat (8) tick(1'b0, "glitch_settle");
        check_val("glitch_dout", 32'(bus.dout), 32'h0);
        check_val("glitch_busy", 32'(bus.busy), 32'h0);
        check_val("glitch_rise_cnt", 32'(rise_cnt), 32'h0);
        check_val("glitch_cnt", 32'(dut.cnt_q), 32'h0);

        // Clean rise: explicit per-edge timeline.
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, "rise");
            hist[i] = obs;
        end
        check_val("rise_busy_e1", 32'(hist[1][0]), 32'h0);
        check_val("rise_busy_e2", 32'(hist[2][0]), 32'h1);
        check_val("rise_dout_e4", 32'(hist[4][3]), 32'h0);
        check_val("rise_e5", 32'(hist[5]), 32'b1100);
        check_val("rise_e6", 32'(hist[6]), 32'b1000);

        // One-cycle low glitch while high is ignored, then a clean fall.
        fall_cnt = 0;
        tick(1'b0, "hi_glitch");
        repeat (8) tick(1'b1, "hi_glitch_settle");
        check_val("hi_glitch_dout", 32'(bus.dout), 32'h1);
        check_val("hi_glitch_fall_cnt", 32'(fall_cnt), 32'h0);
        run_latency(1'b0, "fall", lat);
        check_val("fall_latency", 32'(lat), 32'(Latency));
        check_val("fall_pulse", 32'(obs), 32'b0010);

        // Reset in the middle of a rise qualification.
        repeat (3) tick(1'b0, "pre_rst_low");
        repeat (4) tick(1'b1, "pre_rst_chk");
        check_val("mid_busy", 32'(bus.busy), 32'h1);
        check_val("mid_cnt", 32'(dut.cnt_q), 32'h2);
        #3 rst_n = 1'b0;
        #1 check_val("rst_async", 32'(dut_outs()), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.din_async = ~bus.din_async;
            @(posedge clk);
            #1 check_val("rst_hold", 32'(dut_outs()), 32'h0);
        end
        @(posedge clk);
        #2;
        bus.din_async = 1'b1;
        rst_n         = 1'b1;
        model_reset();
        rise_cnt = 0;
        run_latency(1'b1, "post_rst_rise", lat);
        check_val("post_rst_latency", 32'(lat), 32'(Latency));
        check_val("post_rst_rise_cnt", 32'(rise_cnt), 32'h1);

        // Bounce train then settle high.
        run_latency(1'b0, "to_low", lat);
        check_val("to_low_latency", 32'(lat), 32'(Latency));
        rise_cnt = 0;
        fall_cnt = 0;
        for (int i = 0; i < 20; i++) tick(((i % 2) == 0), "bounce");
        check_val("bounce_dout", 32'(bus.dout), 32'h0);
        run_latency(1'b1, "settle", lat);
        check_val("settle_latency", 32'(lat), 32'(Latency));
        repeat (4) tick(1'b1, "settle_hold");
        check_val("bounce_rise_cnt", 32'(rise_cnt), 32'h1);
        check_val("bounce_fall_cnt", 32'(fall_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw asynchronous input (switch, button, external strobe) into a clean, single-clock-domain level, plus one-cycle edge pulses.
- Sits directly upstream of the team's D flip-flop / register stages; `dout` drives their `d` input.
- Built from a 2-flop synchronizer, a stability counter and a 4-state FSM.
- All logic is posedge `clk`. Downstream negedge flops sample `dout` half a cycle later.

Parameters:
- CNT_W, 16, width of the stability counter.
- STABLE_CYCLES, 4, number of consecutive identical synchronized samples required before `dout` changes. Legal range is 2 to 2^CNT_W−1; use 4 in sim and a large value (for example 50000) in hardware.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- din_async  input  1  raw, unsynchronized, possibly bouncing input.
- dout  output  1  debounced level, registered.
- rise_pulse  output  1  one-cycle high when `dout` goes 0→1, registered.
- fall_pulse  output  1  one-cycle high when `dout` goes 1→0, registered.
- busy  output  1  high while a candidate transition is being qualified (state CHK_HIGH or CHK_LOW).

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - sync0, sync1, cnt, dout, rise_pulse, fall_pulse, busy all 0.
  - state = LOW.
  - Takes effect immediately, mid-qualification included. No pulse is emitted on or after the reset edge.
- Synchronizer: sync0 <= din_async; sync1 <= sync0. Only sync1 feeds the FSM.
- States: LOW, CHK_HIGH, HIGH, CHK_LOW. Encoding is free; `busy` is driven from a registered/decoded state without glitches.
- LOW:
  - sync1=1 → CHK_HIGH, cnt<=1.
  - Otherwise stay, cnt<=0.
- CHK_HIGH:
  - sync1=0 → LOW, cnt<=0 (glitch rejected, no output change).
  - sync1=1 and cnt==STABLE_CYCLES−1 → HIGH, dout<=1, rise_pulse<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- HIGH: mirror of LOW (sync1=0 → CHK_LOW, cnt<=1).
- CHK_LOW: mirror of CHK_HIGH (sync1=1 → HIGH with dout unchanged; qualified → LOW, dout<=0, fall_pulse<=1).
- rise_pulse / fall_pulse:
  - Default 0 every cycle.
  - Each is high for exactly one cycle, coincident with the first cycle `dout` shows the new value.
  - Never both high in the same cycle.
- Latency: din_async captured at edge k → dout changes after edge k+STABLE_CYCLES+1 (k+5 for default). This is the same for both directions.
- Glitch rejection: any excursion of sync1 shorter than STABLE_CYCLES samples causes no change on dout and no pulse.
- Counter: compares against STABLE_CYCLES−1, so it never exceeds STABLE_CYCLES−1 and never wraps.
- Simultaneous events:
  - Input reverting on the exact qualifying cycle means sync1 is not equal to the target level, so the transition is rejected.
  - The rejection takes priority over qualification.
- Reset release with din_async already high: the block starts in LOW and produces a normal qualified rise, including rise_pulse, STABLE_CYCLES+1 edges after the first capture.

Test Plan:
1. Reset check:
   - Stimulus: assert rst_n=0 mid-simulation, with din_async toggling.
   - Response: dout, rise_pulse, fall_pulse, busy = 0 immediately, without waiting for a clk edge; they stay 0 while in reset.
2. Clean rise (STABLE_CYCLES=4):
   - Stimulus: din_async 0→1 before edge 0, held.
   - Response: busy=1 after edge 2; dout=1 and rise_pulse=1 after edge 5; rise_pulse=0 after edge 6; busy=0 after edge 5.
3. Glitch rejection:
   - Stimulus: from LOW, din_async high for 3 cycles, then low.
   - Response: dout stays 0; no rise_pulse; busy returns to 0; cnt back to 0.
4. Clean fall:
   - Stimulus: from HIGH, din_async 1→0 held.
   - Response: dout=0 and fall_pulse=1 exactly 5 edges after capture; a 1-cycle low glitch in HIGH causes no change.
5. Reset mid-qualification:
   - Stimulus: rst_n=0 while busy=1 in CHK_HIGH at cnt=2, released with din_async=1.
   - Response: outputs 0 at once; after release, a full fresh qualification follows (dout=1 exactly 5 edges after the first post-release capture); no early rise.
6. Bounce train:
   - Stimulus: din_async toggles every cycle for 20 cycles, then settles high.
   - Response: exactly one rise_pulse; dout=1 5 edges after the settling capture; no fall_pulse at any point.
